// File: rtl/serial_tx_engine_if.sv
// Handshake/data bundle between the flow controller (master) and the serial
// transmit engine (slave).
interface serial_tx_engine_if #(
    parameter int DATA_WIDTH = 8
);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] dataIn;
    logic                  sampleData;
    logic                  txData;
    logic                  txSerial;
    logic                  txBusy;
    logic                  txDone;
    logic [IDX_W-1:0]      bitIdx;

    modport master (
        output dataIn, sampleData, txData,
        input  txSerial, txBusy, txDone, bitIdx
    );

    modport slave (
        input  dataIn, sampleData, txData,
        output txSerial, txBusy, txDone, bitIdx
    );
endinterface

// File: rtl/serial_tx_engine.sv
// UART-style transmit stage: start bit, LSB-first data, optional even parity,
// stop bit(s), then a level-held txDone until the controller drops txData.
module serial_tx_engine #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input logic               clk,
    input logic               reset,
    serial_tx_engine_if.slave bus
);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
    } state_t;

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] hold_reg, hold_n;
    logic [DATA_WIDTH-1:0] shift_reg, shift_n;
    logic [TMR_W-1:0]      bit_timer, timer_n;
    logic [CNT_W-1:0]      bit_cnt, cnt_n;
    logic                  parity_acc, parity_n;
    logic                  bit_end;

    logic                  serial_q, serial_n;
    logic                  busy_q, busy_n;
    logic                  done_q, done_n;
    logic [IDX_W-1:0]      idx_q, idx_n;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_n  = state;
        hold_n   = hold_reg;
        shift_n  = shift_reg;
        timer_n  = bit_timer;
        cnt_n    = bit_cnt;
        parity_n = parity_acc;
        bit_end  = (bit_timer == TMR_W'(CLKS_PER_BIT - 1));

        if (state != S_IDLE && state != S_DONE)
            timer_n = bit_end ? '0 : bit_timer + 1'b1;

        unique case (state)
            S_IDLE: begin
                if (bus.sampleData)
                    hold_n = bus.dataIn;
                if (bus.txData) begin
                    state_n  = S_START;
                    // Same-edge capture bypasses the holding register.
                    shift_n  = bus.sampleData ? bus.dataIn : hold_reg;
                    parity_n = 1'b0;
                end
            end
            S_START: if (bit_end) state_n = S_DATA;
            S_DATA: begin
                if (bit_end) begin
                    shift_n  = shift_reg >> 1;
                    parity_n = parity_acc ^ shift_reg[0];
                    cnt_n    = bit_cnt + 1'b1;
                    if (bit_cnt == CNT_W'(DATA_WIDTH - 1))
                        state_n = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: if (bit_end) state_n = S_STOP;
            S_STOP: begin
                if (bit_end) begin
                    cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == CNT_W'(STOP_BITS - 1))
                        state_n = S_DONE;
                end
            end
            S_DONE: if (!bus.txData) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        if (state_n != state) begin
            timer_n = '0;
            cnt_n   = '0;
        end

        // Outputs are decoded from the next state so they leave a register.
        serial_n = 1'b1;
        busy_n   = 1'b0;
        done_n   = 1'b0;
        idx_n    = '0;
        unique case (state_n)
            S_START: begin
                serial_n = 1'b0;
                busy_n   = 1'b1;
            end
            S_DATA: begin
                serial_n = shift_n[0];
                busy_n   = 1'b1;
                idx_n    = cnt_n[IDX_W-1:0];
            end
            S_PARITY: begin
                serial_n = parity_n;
                busy_n   = 1'b1;
            end
            S_STOP:  busy_n = 1'b1;
            S_DONE:  done_n = 1'b1;
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            hold_reg   <= '0;
            shift_reg  <= '0;
            bit_timer  <= '0;
            bit_cnt    <= '0;
            parity_acc <= 1'b0;
            serial_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            idx_q      <= '0;
        end else begin
            state      <= state_n;
            hold_reg   <= hold_n;
            shift_reg  <= shift_n;
            bit_timer  <= timer_n;
            bit_cnt    <= cnt_n;
            parity_acc <= parity_n;
            serial_q   <= serial_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
            idx_q      <= idx_n;
        end
    end

    assign bus.txSerial = serial_q;
    assign bus.txBusy   = busy_q;
    assign bus.txDone   = done_q;
    assign bus.bitIdx   = idx_q;
endmodule

// File: tb/tb_serial_tx_engine.sv
// Drives a no-parity and an even-parity engine in lockstep and checks each
// frame cycle by cycle against a scoreboard of expected words.
module tb_serial_tx_engine;
    localparam int DW  = 8;
    localparam int CPB = 4;
    localparam int LEN_N = (1 + DW + 0 + 1) * CPB;
    localparam int LEN_P = (1 + DW + 1 + 1) * CPB;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic          sample_data = 1'b0;
    logic          tx_data = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] exp_q[$];

    serial_tx_engine_if #(.DATA_WIDTH(DW)) bif_n ();
    serial_tx_engine_if #(.DATA_WIDTH(DW)) bif_p ();

    assign bif_n.dataIn = data_in;
    assign bif_n.sampleData = sample_data;
    assign bif_n.txData = tx_data;
    assign bif_p.dataIn = data_in;
    assign bif_p.sampleData = sample_data;
    assign bif_p.txData = tx_data;

    serial_tx_engine #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1))
        dut_n (.clk(clk), .reset(reset), .bus(bif_n.slave));
    serial_tx_engine #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1))
        dut_p (.clk(clk), .reset(reset), .bus(bif_p.slave));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(negedge clk);
    endtask

    // Line value for sample 'cyc' of a frame carrying word w (cyc 0 = first cycle after start).
    function automatic logic exp_serial(input logic [DW-1:0] w, input int cyc, input int par);
        int slot;
        slot = cyc / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= DW) return w[slot-1];
        if (par != 0 && slot == DW + 1) return ^w;
        return 1'b1;
    endfunction

    function automatic logic [2:0] exp_idx(input int cyc);
        int slot;
        slot = cyc / CPB;
        if (slot >= 1 && slot <= DW) return 3'(slot - 1);
        return 3'd0;
    endfunction

    // mode 0: sample then request; 1: sample and request together; 2: request only.
    task automatic start_frame(input int mode, input logic [DW-1:0] w);
        if (mode == 0) begin
            data_in = w;
            sample_data = 1'b1;
            tick;
            sample_data = 1'b0;
            data_in = ~w;
        end else if (mode == 1) begin
            data_in = w;
            sample_data = 1'b1;
        end
        tx_data = 1'b1;
        exp_q.push_back(w);
        tick;
        sample_data = 1'b0;
    endtask

    task automatic check_frame(input string name, input bit hold);
        logic [DW-1:0] w;
        int wait_cnt, busy_cnt_n, busy_cnt_p, err_n, err_p, first_n, first_p;
        logic e_ser_n, e_ser_p, e_done_n, e_done_p;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s scoreboard: queue empty, expected a pending word", name);
            return;
        end
        w = exp_q.pop_front();
        wait_cnt = 0;
        while (!bif_n.txBusy && wait_cnt < 8) begin
            tick;
            wait_cnt++;
        end
        if (wait_cnt !== 0) begin
            n_fail++;
            $display("FAIL %s latency: txBusy after %0d cycles, required 0", name, wait_cnt);
        end
        busy_cnt_n = 0; busy_cnt_p = 0; err_n = 0; err_p = 0; first_n = -1; first_p = -1;
        for (int cyc = 0; cyc < LEN_P + 4; cyc++) begin
            e_ser_n  = exp_serial(w, cyc, 0);
            e_ser_p  = exp_serial(w, cyc, 1);
            e_done_n = hold ? (cyc >= LEN_N) : (cyc == LEN_N);
            e_done_p = hold ? (cyc >= LEN_P) : (cyc == LEN_P);
            if (bif_n.txSerial !== e_ser_n || bif_n.txBusy !== (cyc < LEN_N) ||
                bif_n.txDone !== e_done_n || bif_n.bitIdx !== exp_idx(cyc)) begin
                if (err_n == 0) first_n = cyc;
                err_n++;
            end
            if (bif_p.txSerial !== e_ser_p || bif_p.txBusy !== (cyc < LEN_P) ||
                bif_p.txDone !== e_done_p || bif_p.bitIdx !== exp_idx(cyc)) begin
                if (err_p == 0) first_p = cyc;
                err_p++;
            end
            if (bif_n.txBusy) busy_cnt_n++;
            if (bif_p.txBusy) busy_cnt_p++;
            tick;
        end
        n_tests += 4;
        if (err_n !== 0) begin
            n_fail++;
            $display("FAIL %s stream_noparity word=%h: %0d bad cycles, first at %0d, required 0",
                     name, w, err_n, first_n);
        end
        if (err_p !== 0) begin
            n_fail++;
            $display("FAIL %s stream_parity word=%h: %0d bad cycles, first at %0d, required 0",
                     name, w, err_p, first_p);
        end
        if (busy_cnt_n !== LEN_N) begin
            n_fail++;
            $display("FAIL %s busy_len_noparity: %0d, required %0d", name, busy_cnt_n, LEN_N);
        end
        if (busy_cnt_p !== LEN_P) begin
            n_fail++;
            $display("FAIL %s busy_len_parity: %0d, required %0d", name, busy_cnt_p, LEN_P);
        end
    endtask

    task automatic end_frame(input string name);
        tx_data = 1'b0;
        tick;
        n_tests++;
        if (bif_n.txDone !== 1'b0 || bif_p.txDone !== 1'b0 ||
            bif_n.txSerial !== 1'b1 || bif_p.txSerial !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done_release: done=%b/%b serial=%b/%b, required 0/0 1/1", name,
                     bif_n.txDone, bif_p.txDone, bif_n.txSerial, bif_p.txSerial);
        end
    endtask

    task automatic test_reset;
        int bad;
        reset = 1'b1;
        repeat (3) tick;
        reset = 1'b0;
        tick;
        n_tests++;
        if (bif_n.txSerial !== 1'b1 || bif_n.txBusy !== 1'b0 || bif_n.txDone !== 1'b0 ||
            bif_p.txSerial !== 1'b1 || bif_p.txBusy !== 1'b0 || bif_p.txDone !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: serial=%b busy=%b done=%b, required 1 0 0",
                     bif_n.txSerial, bif_n.txBusy, bif_n.txDone);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (bif_n.txSerial !== 1'b1 || bif_n.txBusy !== 1'b0 || bif_n.txDone !== 1'b0 ||
                bif_p.txSerial !== 1'b1 || bif_p.txBusy !== 1'b0 || bif_p.txDone !== 1'b0 ||
                bif_n.bitIdx !== 3'd0)
                bad++;
            tick;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL reset_idle_hold: %0d bad cycles, required 0", bad);
        end
    endtask

    task automatic test_basic;
        start_frame(0, 8'hA5);
        check_frame("basic", 1'b1);
        end_frame("basic");
    endtask

    task automatic test_parity;
        start_frame(0, 8'h07);
        check_frame("parity_07", 1'b1);
        end_frame("parity_07");
        start_frame(0, 8'hA5);
        check_frame("parity_A5", 1'b1);
        end_frame("parity_A5");
    endtask

    task automatic test_bypass;
        start_frame(1, 8'h3C);
        fork
            check_frame("bypass", 1'b1);
            begin
                repeat (10) tick;
                data_in = 8'hFF;
                sample_data = 1'b1;
                tick;
                sample_data = 1'b0;
            end
        join
        end_frame("bypass");
        start_frame(2, 8'h3C);
        check_frame("held_after_ignore", 1'b1);
        end_frame("held_after_ignore");
    endtask

    task automatic test_txdata_drop;
        start_frame(0, 8'h96);
        fork
            check_frame("txdata_drop", 1'b0);
            begin
                repeat (12) tick;
                tx_data = 1'b0;
            end
        join
    endtask

    task automatic test_reset_mid;
        data_in = 8'h5A;
        sample_data = 1'b1;
        tick;
        sample_data = 1'b0;
        tx_data = 1'b1;
        tick;
        repeat (1 + 3 * CPB + CPB) tick;
        n_tests++;
        if (bif_n.bitIdx !== 3'd3 || bif_p.bitIdx !== 3'd3) begin
            n_fail++;
            $display("FAIL reset_mid_pos: bitIdx=%0d/%0d, required 3/3", bif_n.bitIdx, bif_p.bitIdx);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (bif_n.txSerial !== 1'b1 || bif_n.txBusy !== 1'b0 ||
            bif_p.txSerial !== 1'b1 || bif_p.txBusy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_abort: serial=%b/%b busy=%b/%b, required 1/1 0/0",
                     bif_n.txSerial, bif_p.txSerial, bif_n.txBusy, bif_p.txBusy);
        end
        tx_data = 1'b0;
        tick;
        tick;
        reset = 1'b0;
        tick;
        start_frame(0, 8'h55);
        check_frame("after_reset", 1'b1);
        end_frame("after_reset");
    endtask

    task automatic test_handshake;
        int bad;
        start_frame(0, 8'hC3);
        check_frame("handshake", 1'b1);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (bif_n.txDone !== 1'b1 || bif_n.txBusy !== 1'b0 || bif_n.txSerial !== 1'b1 ||
                bif_p.txDone !== 1'b1 || bif_p.txBusy !== 1'b0 || bif_p.txSerial !== 1'b1)
                bad++;
            tick;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL handshake_hold: %0d bad cycles, required 0", bad);
        end
        end_frame("handshake");
        start_frame(2, 8'hC3);
        check_frame("back_to_back", 1'b1);
        end_frame("back_to_back");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_bypass();
        test_txdata_drop();
        test_reset_mid();
        test_handshake();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
